coherence_dir_ctrl: RTL

Transaction sequencer for the L1 coherence directory. It initialises every directory line after reset and round-robin arbitrates coherence requests from N_SHARERS L1 caches. For each granted request it reads the sharer mask, issues invalidations and collects acks, writes the updated mask back, and returns a response. One transaction is in flight at a time; the directory's set-owner/sharer-mask port is driven only by this block.

---
 rtl/coherence_dir_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/coherence_dir_ctrl.sv
// Coherence directory transaction sequencer: initialises the directory after reset, then
// round-robin grants L1 requests and runs lookup / invalidate / ack-collect / update / respond.
module coherence_dir_ctrl #(
  parameter  int N_LINES     = 1024,
  parameter  int N_SHARERS   = 8,
  parameter  int ACK_TIMEOUT = 255,
  localparam int IDX_W       = $clog2(N_LINES),
  localparam int ID_W        = $clog2(N_SHARERS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SHARERS-1:0]      req_valid,
  output logic [N_SHARERS-1:0]      req_ready,
  input  logic [2*N_SHARERS-1:0]    req_op,
  input  logic [IDX_W*N_SHARERS-1:0] req_idx,
  output logic [IDX_W-1:0]          dir_idx,
  output logic                      dir_set,
  output logic [N_SHARERS-1:0]      dir_wr_mask,
  input  logic [N_SHARERS-1:0]      dir_rd_mask,
  output logic                      inv_valid,
  output logic [N_SHARERS-1:0]      inv_mask,
  output logic [IDX_W-1:0]          inv_idx,
  input  logic [N_SHARERS-1:0]      inv_ack,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [1:0]                resp_op,
  output logic [IDX_W-1:0]          resp_idx,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] OP_GETS = 2'b00;
  localparam logic [1:0] OP_GETM = 2'b01;
  localparam logic [1:0] OP_PUTX = 2'b10;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_LOOKUP   = 3'd2,
    S_EVAL     = 3'd3,
    S_INVAL    = 3'd4,
    S_WAIT_ACK = 3'd5,
    S_UPDATE   = 3'd6,
    S_RESP     = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_init_cnt;
  logic [ID_W-1:0]       r_ptr;
  logic                  r_terr;
  logic [ID_W-1:0]       r_id;
  logic [1:0]            r_op;
  logic [IDX_W-1:0]      r_idx;
  logic [N_SHARERS-1:0]  r_new_mask;
  logic [N_SHARERS-1:0]  r_pend;
  logic [TMR_W-1:0]      r_timer;

  logic                  w_gnt_any;
  logic [ID_W-1:0]       w_gnt_id;
  logic [ID_W-1:0]       w_cand;
  logic                  w_xfer;
  logic [N_SHARERS-1:0]  w_self;
  logic [N_SHARERS-1:0]  w_others;
  logic [N_SHARERS-1:0]  w_pend_nxt;
  logic                  w_tmo;

  // Round-robin search: scanning from the far end down leaves the nearest candidate to ptr.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_cand    = '0;
    for (int k = N_SHARERS - 1; k >= 0; k--) begin
      w_cand = r_ptr + ID_W'(k);
      if (req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_cand;
      end
    end
  end

  assign w_xfer     = (r_state == S_IDLE) && w_gnt_any;
  assign w_self     = N_SHARERS'(1) << r_id;
  assign w_others   = dir_rd_mask & ~w_self;
  assign w_pend_nxt = r_pend & ~inv_ack;
  assign w_tmo      = (r_timer == TMR_W'(ACK_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:     if (r_init_cnt == IDX_W'(N_LINES - 1)) w_next = S_IDLE;
      S_IDLE:     if (w_gnt_any) w_next = S_LOOKUP;
      S_LOOKUP:   w_next = S_EVAL;
      S_EVAL: begin
        case (r_op)
          OP_GETS, OP_PUTX: w_next = S_UPDATE;
          OP_GETM:          w_next = (w_others == '0) ? S_UPDATE : S_INVAL;
          default:          w_next = S_RESP;
        endcase
      end
      S_INVAL:    w_next = S_WAIT_ACK;
      S_WAIT_ACK: if ((w_pend_nxt == '0) || w_tmo) w_next = S_UPDATE;
      S_UPDATE:   w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_cnt <= '0;
      r_ptr      <= '0;
      r_terr     <= 1'b0;
    end else begin
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + IDX_W'(1);
      if (w_xfer)            r_ptr      <= w_gnt_id + ID_W'(1);
      if ((r_state == S_WAIT_ACK) && (w_pend_nxt != '0) && w_tmo) r_terr <= 1'b1;
    end
  end

  // Transaction payload; every field is written before the state that consumes it.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_id  <= w_gnt_id;
      r_op  <= req_op[2*w_gnt_id +: 2];
      r_idx <= req_idx[IDX_W*w_gnt_id +: IDX_W];
    end
    if (r_state == S_EVAL) begin
      case (r_op)
        OP_GETS: r_new_mask <= dir_rd_mask | w_self;
        OP_GETM: r_new_mask <= w_self;
        default: r_new_mask <= dir_rd_mask & ~w_self;
      endcase
      r_pend <= (r_op == OP_GETM) ? w_others : '0;
    end
    if (r_state == S_INVAL) r_timer <= '0;
    if (r_state == S_WAIT_ACK) begin
      r_pend  <= w_pend_nxt;
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_terr;

  // Strobes are masked while rst_n is low so an aborted transaction emits nothing.
  always_comb begin
    req_ready   = '0;
    dir_idx     = '0;
    dir_set     = 1'b0;
    dir_wr_mask = '0;
    inv_valid   = 1'b0;
    inv_mask    = '0;
    inv_idx     = '0;
    resp_valid  = 1'b0;
    resp_id     = '0;
    resp_op     = '0;
    resp_idx    = '0;
    if (rst_n) begin
      case (r_state)
        S_INIT: begin
          dir_set = 1'b1;
          dir_idx = r_init_cnt;
        end
        S_IDLE:   if (w_gnt_any) req_ready = N_SHARERS'(1) << w_gnt_id;
        S_LOOKUP, S_EVAL, S_WAIT_ACK: dir_idx = r_idx;
        S_INVAL: begin
          dir_idx   = r_idx;
          inv_valid = 1'b1;
          inv_mask  = r_pend;
          inv_idx   = r_idx;
        end
        S_UPDATE: begin
          dir_idx     = r_idx;
          dir_set     = 1'b1;
          dir_wr_mask = r_new_mask;
        end
        S_RESP: begin
          dir_idx    = r_idx;
          resp_valid = 1'b1;
          resp_id    = r_id;
          resp_op    = r_op;
          resp_idx   = r_idx;
        end
        default: ;
      endcase
    end
  end

endmodule
